// File: rtl/lpc_autocorr.sv
// Frame autocorrelation R[0..ORDER] over an N-sample buffer.
// One multiply-accumulate per two cycles through a combinational read port.
module lpc_autocorr #(
    parameter int N     = 160,
    parameter int ORDER = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [7:0]         raddr,
    input  logic signed [15:0] rdata,
    output logic               busy,
    output logic               r_valid,
    output logic [3:0]         r_lag,
    output logic signed [39:0] r_value,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD_A = 2'd1;
    localparam logic [1:0] S_RD_B = 2'd2;

    localparam logic [7:0] N_LAST = 8'(N - 1);
    localparam logic [7:0] K_LAST = 8'(ORDER);

    logic [1:0]         state_q, state_d;
    logic [7:0]         k_q, k_d;
    logic [7:0]         n_q, n_d;
    logic signed [39:0] acc_q, acc_d;
    logic signed [15:0] xa_q, xa_d;
    logic               r_valid_q, r_valid_d;
    logic               done_q, done_d;
    logic [3:0]         r_lag_q, r_lag_d;
    logic signed [39:0] r_value_q, r_value_d;

    logic signed [31:0] prod;
    logic signed [39:0] sum;

    // Exact 16x16 product, sign-extended into the 40-bit accumulator
    assign prod = xa_q * rdata;
    assign sum  = acc_q + {{8{prod[31]}}, prod};

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        acc_d     = acc_q;
        xa_d      = xa_q;
        r_valid_d = 1'b0;
        done_d    = 1'b0;
        r_lag_d   = r_lag_q;
        r_value_d = r_value_q;
        raddr     = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = 8'd0;
                    n_d     = 8'd0;
                    acc_d   = '0;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                raddr   = n_q;
                xa_d    = rdata;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                raddr = n_q - k_q;
                if (n_q != N_LAST) begin
                    acc_d   = sum;
                    n_d     = n_q + 8'd1;
                    state_d = S_RD_A;
                end else begin
                    r_value_d = sum;
                    r_lag_d   = k_q[3:0];
                    r_valid_d = 1'b1;
                    if (k_q != K_LAST) begin
                        // Next lag begins at n = k+1 so n-k never underflows
                        k_d     = k_q + 8'd1;
                        n_d     = k_q + 8'd1;
                        acc_d   = '0;
                        state_d = S_RD_A;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            xa_q      <= '0;
            r_valid_q <= 1'b0;
            done_q    <= 1'b0;
            r_lag_q   <= '0;
            r_value_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            xa_q      <= xa_d;
            r_valid_q <= r_valid_d;
            done_q    <= done_d;
            r_lag_q   <= r_lag_d;
            r_value_q <= r_value_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign r_valid = r_valid_q;
    assign done    = done_q;
    assign r_lag   = r_lag_q;
    assign r_value = r_value_q;

endmodule

// File: tb/tb_lpc_autocorr.sv
// Bench for lpc_autocorr: pattern table plus scoreboard of
// expected (lag, value, cycle) strobes, with abort and restart sequences.
module tb_lpc_autocorr;

    localparam int N = 160;
    localparam int ORDER = 10;
    localparam int DONE_CYC = 3411;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [7:0]         raddr;
    logic signed [15:0] rdata;
    logic               busy;
    logic               r_valid;
    logic [3:0]         r_lag;
    logic signed [39:0] r_value;
    logic               done;

    logic signed [15:0] mem [0:N-1];
    assign rdata = mem[raddr];

    lpc_autocorr #(.N(N), .ORDER(ORDER)) dut (
        .clk(clk), .reset(reset), .start(start),
        .raddr(raddr), .rdata(rdata), .busy(busy),
        .r_valid(r_valid), .r_lag(r_lag), .r_value(r_value),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 pat;
        logic signed [39:0] r0;
        logic signed [39:0] r1;
        logic signed [39:0] r2;
        logic signed [39:0] r10;
    } vec_t;

    typedef struct {
        int                 lag;
        logic signed [39:0] val;
        int                 cyc;
    } exp_t;

    exp_t               q[$];
    vec_t               tab[4];
    logic signed [39:0] got_r [0:ORDER];
    int                 cyc;
    int                 total = 0;
    int                 bad = 0;

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0: mem[i] = 16'sh0001;
                1: mem[i] = 16'sh8000;
                2: mem[i] = (i % 2 == 0) ? 16'sh0001 : -16'sh0001;
                default: mem[i] = (i == 5) ? 16'sd100 : 16'sd0;
            endcase
        end
    endtask

    function automatic logic signed [39:0] ref_r(input int k);
        longint s = 0;
        for (int n = k; n < N; n++)
            s += longint'(mem[n]) * longint'(mem[n-k]);
        return 40'(s);
    endfunction

    function automatic int exp_cyc(input int k);
        int c = 1;
        for (int j = 0; j <= k; j++) c += 2 * (N - j);
        return c;
    endfunction

    task automatic push_expect();
        for (int k = 0; k <= ORDER; k++)
            q.push_back('{k, ref_r(k), exp_cyc(k)});
    endtask

    task automatic launch();
        push_expect();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic watch(input int mid, input int abort_at, input bit chain);
        bit   fin = 1'b0;
        bit   oob = 1'b0;
        bit   spur = 1'b0;
        int   guard = 0;
        exp_t e;
        while (!fin && guard < 4000) begin
            guard++;
            if (raddr >= 8'(N)) oob = 1'b1;
            if (cyc == 1) chk("busy_first", 40'(busy), 40'd1);
            if (r_valid) begin
                if (q.size() == 0) begin
                    chk("extra_strobe", 40'd1, 40'd0);
                end else begin
                    e = q.pop_front();
                    chk("r_lag", 40'(r_lag), 40'(e.lag));
                    chk("r_value", r_value, e.val);
                    chk("strobe_cyc", 40'(cyc), 40'(e.cyc));
                    got_r[e.lag] = r_value;
                end
            end
            if (done) begin
                chk("done_cyc", 40'(cyc), 40'(DONE_CYC));
                chk("busy_done", 40'(busy), 40'd0);
                chk("q_empty", 40'(q.size()), 40'd0);
                fin = 1'b1;
                if (chain) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("busy_restart", 40'(busy), 40'd1);
                    push_expect();
                    cyc = 1;
                end
            end else if (cyc == abort_at) begin
                reset = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                q.delete();
                chk("abort_busy", 40'(busy), 40'd0);
                chk("abort_valid", 40'(r_valid), 40'd0);
                repeat (700) begin
                    @(posedge clk); #1;
                    if (r_valid || done || busy) spur = 1'b1;
                end
                chk("abort_quiet", 40'(spur), 40'd0);
                fin = 1'b1;
            end else begin
                if (cyc == mid) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end
        end
        if (!fin) chk("timeout", 40'd0, 40'd1);
        chk("raddr_range", 40'(oob), 40'd0);
    endtask

    initial begin
        tab[0] = '{0, 40'sd160, 40'sd159, 40'sd158, 40'sd150};
        tab[1] = '{1, 40'sh2800000000, 40'sh27C0000000,
                   40'sh2780000000, 40'sh2580000000};
        tab[2] = '{2, 40'sd160, 40'shFFFFFFFF61, 40'sd158, 40'sd150};
        tab[3] = '{3, 40'sd10000, 40'sd0, 40'sd0, 40'sd0};

        reset = 1'b0;
        start = 1'b1;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_valid", 40'(r_valid), 40'd0);
        chk("rst_done", 40'(done), 40'd0);
        chk("rst_raddr", 40'(raddr), 40'd0);
        chk("rst_lag", 40'(r_lag), 40'd0);
        chk("rst_value", r_value, 40'd0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            fill(tab[i].pat);
            launch();
            watch(-1, -1, 1'b0);
            chk("tab_r0", got_r[0], tab[i].r0);
            chk("tab_r1", got_r[1], tab[i].r1);
            chk("tab_r2", got_r[2], tab[i].r2);
            chk("tab_r10", got_r[10], tab[i].r10);
            chk("hold_value", r_value, tab[i].r10);
            chk("hold_lag", 40'(r_lag), 40'(ORDER));
        end

        fill(0);
        launch();
        watch(-1, 100, 1'b0);
        launch();
        watch(-1, -1, 1'b0);
        chk("fresh_r0", got_r[0], 40'sd160);
        chk("fresh_r10", got_r[10], 40'sd150);

        fill(2);
        launch();
        watch(50, -1, 1'b1);
        watch(-1, -1, 1'b0);
        chk("second_r1", got_r[1], 40'shFFFFFFFF61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpc_autocorr.md
LPC_AUTOCORR -- requirements
Module: lpc_autocorr

Interface
- REQ-001 Parameter N, default 160: samples per frame, range 2..256.
- REQ-002 Parameter ORDER, default 10: highest lag computed; SHALL satisfy ORDER < N.
- REQ-003 clk  input  1: single clock; all state updates on the rising edge.
- REQ-004 reset  input  1: synchronous, active-low reset.
- REQ-005 start  input  1: request to compute one frame; sampled only in IDLE.
- REQ-006 raddr  output  8: sample buffer read address (word index).
- REQ-007 rdata  input  16: signed sample from the buffer, valid in the same cycle as raddr (combinational read).
- REQ-008 busy  output  1: high while a frame computation is in progress.
- REQ-009 r_valid  output  1: one-cycle strobe; r_lag and r_value are valid.
- REQ-010 r_lag  output  4: lag index k of the current result.
- REQ-011 r_value  output  40: signed autocorrelation R[k].
- REQ-012 done  output  1: one-cycle pulse; all lags 0..ORDER have been delivered.

Function
- REQ-013 Block SHALL compute R[k] = sum over n=k..N-1 of x[n]*x[n-k] for k=0..ORDER, in ascending k.
- REQ-014 Products SHALL be 16x16 signed to 32 bits, sign-extended into a 40-bit accumulator; no saturation or rounding (N*2^30 < 2^39, so the result is exact).
- REQ-015 States: IDLE, RD_A, RD_B; internal counters k (lag) and n (sample index).
- REQ-016 IDLE: busy=0, raddr=0; start=1 -> k=0, n=0, acc=0, go to RD_A.
- REQ-017 RD_A: raddr=n; latch xa<=rdata; go to RD_B.
- REQ-018 RD_B: raddr=n-k; acc<=acc+xa*rdata; if n<N-1 then n<=n+1 and go to RD_A.
- REQ-019 RD_B with n==N-1: r_value<=acc+xa*rdata, r_lag<=k, r_valid<=1 for the next cycle only.
- REQ-020 In that same cycle, if k<ORDER then k<=k+1, n<=k+1, acc<=0, and go to RD_A.
- REQ-021 In that same cycle, if k==ORDER then done<=1 for one cycle and go to IDLE.
- REQ-022 Each product SHALL take 2 cycles; lag k SHALL take 2*(N-k) cycles.
- REQ-023 With start sampled at edge 0, r_valid for lag k SHALL be high in cycle 1 + sum over j=0..k of 2*(N-j).
- REQ-024 With defaults: lag 0 valid in cycle 321; lag 10 valid and done in cycle 3411.
- REQ-025 busy SHALL be 1 in every RD_A/RD_B cycle and 0 otherwise; busy is 0 in the done cycle.
- REQ-026 start while busy SHALL be ignored; no queuing.
- REQ-027 start asserted in the done cycle (state IDLE) SHALL be accepted and start a new frame.
- REQ-028 r_lag and r_value SHALL hold their last values between r_valid strobes.
- REQ-029 raddr SHALL always lie within 0..N-1.
- REQ-030 The upstream writer SHALL NOT modify the buffer while busy=1; if it does, results are undefined.

Reset
- REQ-031 reset=0 at a rising edge SHALL force: IDLE; busy=0, r_valid=0, done=0, raddr=0, r_lag=0, r_value=0; k, n, acc and xa cleared.
- REQ-032 Reset mid-computation SHALL abort the frame; no r_valid or done for the aborted frame.
- REQ-033 start is ignored while reset=0.

Verification
- REQ-034 Buffer all 0x0001, start -> 11 strobes with r_value = 160-k (R0=160, R10=150); done in cycle 3411.
- REQ-035 Buffer all 0x8000 -> R0 = 0x2800000000, R10 = 150*2^30 = 0x2580000000; no overflow.
- REQ-036 Alternating +1,-1 (x[0]=+1) -> R[k] = (160-k)*(-1)^k; R1 = 0xFFFFFFFF61, R2 = 158.
- REQ-037 Impulse x[5]=100, all other samples 0 -> R0 = 10000, R1..R10 = 0.
- REQ-038 Reset low at cycle 100 for one cycle, then start -> no strobes from the aborted run; the fresh run matches REQ-034 timing and values.
- REQ-039 start pulsed at cycles 50 and 3411 -> the cycle-50 pulse is ignored; the cycle-3411 pulse is accepted, busy=1 in cycle 3412, and the second frame completes.
